// File: rtl/aurora_transmitter.sv
// Credit-gated TX framer: emits CTRL (slot advert) or DATA header + payload from an FWFT FIFO.
// Words leave combinationally from state; one IDLE cycle between packets; holds word while tx_dst_rdy_i=0.
module aurora_transmitter #(
  parameter logic [3:0] CTRL_HEAD   = 4'hC,
  parameter logic [3:0] DATA_HEAD   = 4'hD,
  parameter int         MAX_PKT_LEN = 256,
  parameter int         CTRL_PERIOD = 1024
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [31:0] fifo_data_i,
  input  logic [17:0] fifo_count_i,
  output logic        fifo_rd_en_o,
  input  logic [17:0] local_empty_slots_i,
  input  logic [17:0] partner_empty_slots_i,
  input  logic        partner_empty_slots_valid_i,
  output logic [31:0] tx_data_o,
  output logic        tx_src_rdy_o,
  input  logic        tx_dst_rdy_i
);

  localparam int              TW         = (CTRL_PERIOD > 1) ? $clog2(CTRL_PERIOD) : 1;
  localparam logic [TW-1:0]   TIMER_LAST = TW'(CTRL_PERIOD - 1);
  localparam logic [17:0]     MAX_LEN    = 18'(MAX_PKT_LEN);

  typedef enum logic [1:0] {IDLE, SEND_CTRL, SEND_HEAD, SEND_DATA} state_t;

  state_t          state_q, state_d;
  logic [17:0]     credit_q;
  logic [17:0]     len_q;
  logic [17:0]     remain_q;
  logic [17:0]     ctrl_slots_q;
  logic [TW-1:0]   ctrl_timer_q;
  logic            ctrl_pend_q;

  logic            can_send;
  logic            pay_xfer;
  logic [17:0]     len_min;
  logic [17:0]     credit_base;

  assign can_send = (fifo_count_i != 18'd0) && (credit_q != 18'd0);
  assign pay_xfer = (state_q == SEND_DATA) && tx_dst_rdy_i;

  // Packet length is bounded by FIFO occupancy, credit and max size so neither can underflow.
  always_comb begin
    len_min = fifo_count_i;
    if (credit_q < len_min) len_min = credit_q;
    if (MAX_LEN < len_min)  len_min = MAX_LEN;
  end

  always_comb begin
    credit_base = partner_empty_slots_valid_i ? partner_empty_slots_i : credit_q;
  end

  // FSM: state register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ctrl_pend_q)   state_d = SEND_CTRL;
        else if (can_send) state_d = SEND_HEAD;
      end
      SEND_CTRL: if (tx_dst_rdy_i) state_d = IDLE;
      SEND_HEAD: if (tx_dst_rdy_i) state_d = SEND_DATA;
      SEND_DATA: if (tx_dst_rdy_i && (remain_q == 18'd1)) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    tx_src_rdy_o = 1'b0;
    tx_data_o    = 32'd0;
    fifo_rd_en_o = 1'b0;
    case (state_q)
      SEND_CTRL: begin
        tx_src_rdy_o = 1'b1;
        tx_data_o    = {CTRL_HEAD, 10'd0, ctrl_slots_q};
      end
      SEND_HEAD: begin
        tx_src_rdy_o = 1'b1;
        tx_data_o    = {DATA_HEAD, 10'd0, len_q};
      end
      SEND_DATA: begin
        tx_src_rdy_o = 1'b1;
        tx_data_o    = fifo_data_i;
        fifo_rd_en_o = tx_dst_rdy_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      len_q        <= 18'd0;
      remain_q     <= 18'd0;
      ctrl_slots_q <= 18'd0;
    end else begin
      if (state_q == IDLE) begin
        if (ctrl_pend_q)   ctrl_slots_q <= local_empty_slots_i;
        else if (can_send) len_q        <= len_min;
      end
      if ((state_q == SEND_HEAD) && tx_dst_rdy_i) remain_q <= len_q;
      else if (pay_xfer)                          remain_q <= remain_q - 18'd1;
    end
  end

  // A partner update mid-packet applies at once; saturation guards against a stale low report.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      credit_q <= 18'd0;
    end else if (pay_xfer) begin
      credit_q <= (credit_base == 18'd0) ? 18'd0 : credit_base - 18'd1;
    end else begin
      credit_q <= credit_base;
    end
  end

  // A new period starting on the same cycle a CTRL is accepted keeps the request pending.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ctrl_timer_q <= '0;
      ctrl_pend_q  <= 1'b1;
    end else begin
      if ((state_q == SEND_CTRL) && tx_dst_rdy_i) ctrl_pend_q <= 1'b0;
      if (ctrl_timer_q == TIMER_LAST) begin
        ctrl_timer_q <= '0;
        ctrl_pend_q  <= 1'b1;
      end else begin
        ctrl_timer_q <= ctrl_timer_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aurora_transmitter.sv
// Scoreboard bench: FIFO model feeds the DUT, monitor checks framing, credit use and ordering.
module tb_aurora_transmitter;

  localparam int P   = 200;
  localparam int MAX = 256;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic [31:0] fifo_data_i;
  logic [17:0] fifo_count_i;
  logic        fifo_rd_en_o;
  logic [17:0] local_empty_slots_i;
  logic [17:0] partner_empty_slots_i;
  logic        partner_empty_slots_valid_i;
  logic [31:0] tx_data_o;
  logic        tx_src_rdy_o;
  logic        tx_dst_rdy_i;

  aurora_transmitter #(
    .CTRL_HEAD(4'hC), .DATA_HEAD(4'hD), .MAX_PKT_LEN(MAX), .CTRL_PERIOD(P)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .fifo_data_i(fifo_data_i), .fifo_count_i(fifo_count_i), .fifo_rd_en_o(fifo_rd_en_o),
    .local_empty_slots_i(local_empty_slots_i),
    .partner_empty_slots_i(partner_empty_slots_i),
    .partner_empty_slots_valid_i(partner_empty_slots_valid_i),
    .tx_data_o(tx_data_o), .tx_src_rdy_o(tx_src_rdy_o), .tx_dst_rdy_i(tx_dst_rdy_i)
  );

  always #5 clk_i = ~clk_i;

  logic [31:0] fq[$];     // TX FIFO contents seen by the DUT
  logic [31:0] exp_q[$];  // payload words still expected on the link, in order
  int          hl_q[$];   // header lengths observed
  int n_vec = 0, n_err = 0;
  int ctrl_cnt = 0, rd_cnt = 0;
  int mon_remain = 0;
  bit pop_pend = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int min3(int a, int b, int c);
    int m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    return m;
  endfunction

  // FIFO model: pops the cycle after a read strobe, then presents the new head.
  always begin
    @(posedge clk_i);
    #1;
    if (pop_pend && fq.size() > 0) void'(fq.pop_front());
    pop_pend = 0;
    #1;
    fifo_data_i  = (fq.size() > 0) ? fq[0] : 32'd0;
    fifo_count_i = 18'(fq.size());
  end

  // Monitor with a behavioural model of credit and CTRL scheduling.
  initial begin
    int credit_m, timer_m, prev_snap;
    bit pend_m, prev_pend, prev_src, prev_xfer, skip, cur_xfer, pay, ctrl_acc;
    logic [17:0] prev_local;
    logic [31:0] prev_data;
    credit_m = 0; timer_m = 0; pend_m = 1; prev_snap = 0; prev_pend = 1;
    prev_src = 0; prev_xfer = 0; skip = 1; prev_local = '0; prev_data = '0;
    forever begin
      @(negedge clk_i);
      if (!reset_n_i) begin
        chk("rst_outputs", {tx_src_rdy_o, fifo_rd_en_o, tx_data_o}, 64'd0);
        mon_remain = 0; credit_m = 0; timer_m = 0; pend_m = 1;
        exp_q = fq; pop_pend = 0; skip = 1; prev_src = 0; prev_xfer = 0;
      end else begin
        cur_xfer = tx_src_rdy_o && tx_dst_rdy_i;
        if (skip)
          chk("post_rst_idle", tx_src_rdy_o, 0);
        else if (!prev_src) begin
          if (prev_pend)
            chk("ctrl_word", {tx_src_rdy_o, tx_data_o}, {1'b1, 4'hC, 10'd0, prev_local});
          else if (prev_snap != 0)
            chk("head_word", {tx_src_rdy_o, tx_data_o}, {1'b1, 4'hD, 10'd0, 18'(prev_snap)});
          else
            chk("idle_hold", tx_src_rdy_o, 0);
        end else if (!prev_xfer)
          chk("stall_hold", {tx_src_rdy_o, tx_data_o}, {1'b1, prev_data});
        else if (mon_remain == 0)
          chk("pkt_gap", tx_src_rdy_o, 0);
        else
          chk("data_valid", tx_src_rdy_o, 1);
        chk("rd_en", fifo_rd_en_o, (mon_remain != 0) && tx_dst_rdy_i);

        pay = 0; ctrl_acc = 0;
        if (cur_xfer) begin
          if (mon_remain == 0) begin
            if (tx_data_o[31:28] == 4'hC) begin
              ctrl_cnt++; ctrl_acc = 1;
            end else begin
              mon_remain = int'(tx_data_o[17:0]);
              hl_q.push_back(int'(tx_data_o[17:0]));
            end
          end else begin
            if (exp_q.size() == 0) chk("payload_extra", tx_data_o, 64'hDEAD);
            else chk("payload", tx_data_o, exp_q.pop_front());
            mon_remain--; pay = 1;
          end
        end
        if (fifo_rd_en_o) begin
          pop_pend = 1; rd_cnt++;
        end

        prev_snap  = min3(int'(fifo_count_i), credit_m, MAX);
        prev_pend  = pend_m;
        prev_local = local_empty_slots_i;
        prev_src   = tx_src_rdy_o;
        prev_xfer  = cur_xfer;
        prev_data  = tx_data_o;
        skip       = 0;

        if (partner_empty_slots_valid_i) credit_m = int'(partner_empty_slots_i);
        if (pay && credit_m > 0) credit_m--;
        if (ctrl_acc) pend_m = 0;
        if (timer_m == P - 1) begin
          pend_m = 1; timer_m = 0;
        end else timer_m++;
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_words(int n);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      fq.push_back(w);
      exp_q.push_back(w);
    end
  endtask

  task automatic strobe(int v);
    partner_empty_slots_i       = 18'(v);
    partner_empty_slots_valid_i = 1'b1;
    step();
    partner_empty_slots_valid_i = 1'b0;
  endtask

  task automatic settle(int tgt, string nm);
    int k = 0;
    while (fq.size() != tgt && k < 6000) begin
      step();
      k++;
    end
    repeat (30) step();
    chk(nm, fq.size(), tgt);
  endtask

  initial begin
    int base, c0, r0;
    int exp_l[3];
    exp_l[0] = 256; exp_l[1] = 256; exp_l[2] = 88;
    reset_n_i = 1'b0;
    tx_dst_rdy_i = 1'b1;
    partner_empty_slots_valid_i = 1'b0;
    partner_empty_slots_i = '0;
    local_empty_slots_i = 18'h123;
    fifo_data_i = '0;
    fifo_count_i = '0;
    repeat (3) step();
    reset_n_i = 1'b1;

    // Reset release: one CTRL then idle
    repeat (10) step();
    chk("t1_ctrl_cnt", ctrl_cnt, 1);
    chk("t1_no_reads", rd_cnt, 0);

    // Plain packet, then credit exhaustion at 95
    strobe(100);
    base = rd_cnt;
    push_words(5);
    settle(0, "t2_drain");
    chk("t2_reads", rd_cnt - base, 5);
    push_words(100);
    settle(5, "t2_credit95");
    strobe(1000);
    settle(0, "t2_rest");

    // Small credit windows
    strobe(3);
    push_words(10);
    settle(7, "t3_credit3");
    strobe(4);
    settle(3, "t3_credit4");
    strobe(1000);
    settle(0, "t3_rest");

    // Max packet length split
    strobe(1000);
    hl_q.delete();
    base = rd_cnt;
    push_words(600);
    settle(0, "t4_drain");
    chk("t4_reads", rd_cnt - base, 600);
    chk("t4_pkts", hl_q.size(), 3);
    for (int i = 0; i < 3; i++)
      chk("t4_len", (hl_q.size() > i) ? hl_q[i] : -1, exp_l[i]);

    // Random backpressure, arrivals, credit and advert changes
    for (int i = 0; i < 2500; i++) begin
      tx_dst_rdy_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) push_words($urandom_range(1, 4));
      partner_empty_slots_valid_i = ($urandom_range(0, 29) == 0);
      partner_empty_slots_i = 18'($urandom_range(0, 64));
      if ($urandom_range(0, 99) == 0) local_empty_slots_i = 18'($urandom);
      step();
    end
    partner_empty_slots_valid_i = 1'b0;
    tx_dst_rdy_i = 1'b1;
    strobe(1000);
    settle(0, "t5_drain");

    // Reset mid-packet
    strobe(1000);
    push_words(100);
    repeat (30) step();
    chk("t6_in_packet", mon_remain != 0, 1);
    c0 = ctrl_cnt;
    r0 = rd_cnt;
    reset_n_i = 1'b0;
    repeat (3) step();
    reset_n_i = 1'b1;
    repeat (5) step();
    chk("t6_ctrl_first", ctrl_cnt, c0 + 1);
    chk("t6_no_reads", rd_cnt, r0);
    strobe(1000);
    settle(0, "t6_drain");
    chk("t6_scoreboard_empty", exp_q.size(), 0);

    repeat (5) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
